// File: rtl/multicycle_decoder_if.sv
// Control bundle between the multicycle decoder and the datapath / condition logic.
// The decoder drives the control fields from the instruction fields Op, Funct and Rd.
interface multicycle_decoder_if;
  // No valid/ready handshake: Op/Funct/Rd are sampled every cycle and must stay stable
  // from DECODE to the end of the instruction; all controls are valid every cycle.
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] State;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport master (
    input  Op, Funct, Rd,
    output State, PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Op, Funct, Rd,
    input  State, PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/multicycle_decoder.sv
// Main control FSM and ALU decoder of the multicycle core. Moore outputs are registered
// alongside the state so they change only after clock edges.
module multicycle_decoder (
  input logic               clk,
  input logic               reset,
  multicycle_decoder_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcs;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
  } ctrl_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t state;
  ctrl_t  ctrl;

  function automatic state_t next_of(state_t s, logic [1:0] op, logic [5:0] f);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = DECODE;
      DECODE: begin
        case (op)
          2'b00:   n = f[5] ? EXECUTEI : EXECUTER;
          2'b01:   n = MEMADR;
          2'b10:   n = BRANCH;
          default: n = FETCH;
        endcase
      end
      MEMADR:   n = f[0] ? MEMRD : MEMWR;
      MEMRD:    n = MEMWB;
      EXECUTER: n = ALUWB;
      EXECUTEI: n = ALUWB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(state_t s, logic [5:0] f, logic [3:0] rd);
    ctrl_t c;
    logic  alu_op;
    logic  branch;
    c      = '0;
    alu_op = 1'b0;
    branch = 1'b0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      MEMADR: c.alu_src_b = 2'b01;
      MEMRD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        c.alu_src_b = 2'b01;
        alu_op      = 1'b1;
      end
      ALUWB: c.reg_w = (f[4:1] != CMD_CMP);
      BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        branch       = 1'b1;
      end
      default: c = '0;
    endcase

    if (alu_op) begin
      case (f[4:1])
        CMD_ADD: c.alu_control = 2'b00;
        CMD_SUB: c.alu_control = 2'b01;
        CMD_AND: c.alu_control = 2'b10;
        CMD_ORR: c.alu_control = 2'b11;
        CMD_CMP: c.alu_control = 2'b01;
        default: c.alu_control = 2'b00;
      endcase
      // CMP always updates all flags; other S-suffixed ops touch CV only for ADD/SUB.
      if (f[4:1] == CMD_CMP)
        c.flag_w = 2'b11;
      else if (f[0])
        c.flag_w = {1'b1, (f[4:1] == CMD_ADD) || (f[4:1] == CMD_SUB)};
    end

    c.pcs = (c.reg_w & (rd == 4'hF)) | branch;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= decode(FETCH, bus.Funct, bus.Rd);
    end else begin
      state <= next_of(state, bus.Op, bus.Funct);
      ctrl  <= decode(next_of(state, bus.Op, bus.Funct), bus.Funct, bus.Rd);
    end
  end

  assign bus.State      = state;
  assign bus.PCS        = ctrl.pcs;
  assign bus.NextPC     = ctrl.next_pc;
  assign bus.RegW       = ctrl.reg_w;
  assign bus.MemW       = ctrl.mem_w;
  assign bus.FlagW      = ctrl.flag_w;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = ctrl.alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: the driver queues the hand-computed per-cycle
// control vector of each instruction, and a negedge monitor pops and compares them.
module tb_multicycle_decoder;

  logic clk;
  logic reset;
  multicycle_decoder_if bus ();

  multicycle_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  string       name_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [1:0]  cur_op = 2'b00;

  wire [22:0] act = {bus.State, bus.PCS, bus.NextPC, bus.RegW, bus.MemW, bus.FlagW,
                     bus.IRWrite, bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                     bus.ALUControl, bus.ImmSrc, bus.RegSrc};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                 nm, act, e, act[22:19], e[22:19]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    bus.Op    = op;
    bus.Funct = f;
    bus.Rd    = rd;
    cur_op    = op;
  endtask

  task automatic e(input string nm, input logic [3:0] st, input logic pcs, input logic npc,
                   input logic rw, input logic mw, input logic [1:0] fw, input logic irw,
                   input logic adr, input logic [1:0] rs, input logic sa,
                   input logic [1:0] sb, input logic [1:0] alu);
    exp_q.push_back({st, pcs, npc, rw, mw, fw, irw, adr, rs, sa, sb, alu,
                     cur_op, cur_op == 2'b01, cur_op == 2'b10});
    name_q.push_back(nm);
  endtask

  task automatic e_fetch(input string nm);
    e(nm, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00);
  endtask

  task automatic e_decode(input string nm);
    e(nm, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00);
  endtask

  task automatic e_memadr(input string nm);
    e(nm, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    set_instr(2'b00, 6'b000000, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // STR
    set_instr(2'b01, 6'b011000, 4'd0);
    e_fetch("str_fetch"); e_decode("str_decode"); e_memadr("str_memadr");
    e("str_memwr", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // STR interrupted by a two-cycle reset while in MEMWR
    e_fetch("rst_str_fetch"); e_decode("rst_str_decode"); e_memadr("rst_str_memadr");
    e("rst_str_memwr", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    e_fetch("rst_hold1");
    cycles(1);
    reset = 1'b0;

    // LDR r3
    set_instr(2'b01, 6'b011001, 4'd3);
    e_fetch("ldr_fetch"); e_decode("ldr_decode"); e_memadr("ldr_memadr");
    e("ldr_memrd", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    e("ldr_memwb", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00);
    cycles(5);

    // ADDS register
    set_instr(2'b00, 6'b001001, 4'd2);
    e_fetch("adds_fetch"); e_decode("adds_decode");
    e("adds_exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    e("adds_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // ANDS register
    set_instr(2'b00, 6'b000001, 4'd2);
    e_fetch("ands_fetch"); e_decode("ands_decode");
    e("ands_exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10);
    e("ands_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // CMP immediate
    set_instr(2'b00, 6'b110101, 4'd0);
    e_fetch("cmp_fetch"); e_decode("cmp_decode");
    e("cmp_exec", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01);
    e("cmp_aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // SUBS immediate
    set_instr(2'b00, 6'b100101, 4'd1);
    e_fetch("subs_fetch"); e_decode("subs_decode");
    e("subs_exec", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01);
    e("subs_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // EORS register: unlisted command decodes as add, NZ flags only
    set_instr(2'b00, 6'b000011, 4'd4);
    e_fetch("eors_fetch"); e_decode("eors_decode");
    e("eors_exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    e("eors_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // ORR to r15 requests a PC write in ALUWB
    set_instr(2'b00, 6'b011000, 4'd15);
    e_fetch("orr15_fetch"); e_decode("orr15_decode");
    e("orr15_exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11);
    e("orr15_aluwb", 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    cycles(4);

    // Branch
    set_instr(2'b10, 6'b100000, 4'd0);
    e_fetch("b_fetch"); e_decode("b_decode");
    e("b_branch", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00);
    cycles(3);

    // LDR to r15
    set_instr(2'b01, 6'b011001, 4'd15);
    e_fetch("ldr15_fetch"); e_decode("ldr15_decode"); e_memadr("ldr15_memadr");
    e("ldr15_memrd", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    e("ldr15_memwb", 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00);
    cycles(5);

    // Undefined opcode executes as a NOP
    set_instr(2'b11, 6'b001001, 4'd15);
    e_fetch("undef_fetch"); e_decode("undef_decode");
    cycles(2);

    // Back in FETCH after the NOP
    set_instr(2'b00, 6'b000000, 4'd0);
    e_fetch("final_fetch");
    cycles(1);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
